// File: rtl/spi_dev_memdma.sv
// spi_dev_memdma: SPI write-stream to memory DMA.
// Words assembled from an armed SPI write stream are buffered in a FIFO and
// written out as bursts of up to BURST_LEN words, with optional ring-buffer
// addressing. A 4-register Wishbone slave controls and monitors the engine.
module spi_dev_memdma #(
  parameter logic [7:0] CMD_BYTE   = 8'he0,
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 23,
  parameter int         BURST_LEN  = 64,
  parameter int         FIFO_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            pw_wdata,
  input  logic                  pw_wcmd,
  input  logic                  pw_wstb,
  input  logic                  pw_end,
  output logic [ADDR_WIDTH-1:0] mi_addr,
  output logic [6:0]            mi_len,
  output logic                  mi_rw,
  output logic                  mi_valid,
  input  logic                  mi_ready,
  output logic [DATA_WIDTH-1:0] mi_wdata,
  input  logic                  mi_wack,
  input  logic                  mi_wlast,
  input  logic [DATA_WIDTH-1:0] mi_rdata,
  input  logic                  mi_rstb,
  input  logic                  mi_rlast,
  input  logic [31:0]           wb_wdata,
  output logic [31:0]           wb_rdata,
  input  logic [1:0]            wb_addr,
  input  logic                  wb_we,
  input  logic                  wb_cyc,
  output logic                  wb_ack
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (ADDR_WIDTH > LW) ? ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8)
                                        : ((LW > 8) ? LW : 8);
  localparam logic [7:0]    LAST_BYTE = 8'(DATA_WIDTH / 8 - 1);
  localparam logic [LW-1:0] BURST_LVL = LW'(BURST_LEN);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT} state_t;

  state_t state_q, state_d;

  logic                  armed, txn_pushed, push_pend;
  logic [7:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] shreg, push_word;
  logic                  byte_ok, word_done, end_flush;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  full, push, pop;

  logic                  run, flush, ovf, busy;
  logic [ADDR_WIDTH-1:0] base, off, ring, off_sum;
  logic [31:0]           wcount;
  logic [6:0]            lenm1;
  logic [7:0]            len, len_calc;
  logic                  launch, accept, done;
  logic                  wr_pend;
  logic [1:0]            wr_addr;
  logic [31:0]           wr_data, rd_mux;
  logic [CW-1:0]         cand, ring_rem;
  logic                  unused_inputs;

  assign byte_ok   = pw_wstb & ~pw_wcmd & armed;
  assign word_done = byte_ok & (byte_cnt == LAST_BYTE);
  // A transaction that produced at least one word (even one still in flight) requests a flush
  assign end_flush = pw_end & (txn_pushed | push_pend | word_done);

  assign full     = (level == FULL_LVL);
  assign push     = push_pend & ~full;
  assign pop      = (state_q == ST_WAIT) & mi_wack & (level != '0);
  assign mi_wdata = mem[rd_ptr];
  assign mi_rw    = 1'b0;
  assign busy     = (state_q != ST_IDLE);
  assign len      = {1'b0, lenm1} + 8'd1;
  assign mi_len   = lenm1;
  assign mi_addr  = base + off;
  assign off_sum  = off + ADDR_WIDTH'(len);
  assign unused_inputs = ^{mi_rdata, mi_rstb, mi_rlast, wr_data};

  // Byte stream decoder: arms on the command byte, packs bytes MSB-first into words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b0;
      txn_pushed <= 1'b0;
      push_pend  <= 1'b0;
      byte_cnt   <= '0;
      shreg      <= '0;
      push_word  <= '0;
    end else begin
      push_pend <= 1'b0;
      if (pw_wstb && pw_wcmd) begin
        armed    <= (pw_wdata == CMD_BYTE);
        byte_cnt <= '0;
      end else if (byte_ok) begin
        if (word_done) begin
          push_pend  <= 1'b1;
          push_word  <= DATA_WIDTH'({shreg, pw_wdata});
          byte_cnt   <= '0;
          txn_pushed <= 1'b1;
        end else begin
          shreg    <= DATA_WIDTH'({shreg, pw_wdata});
          byte_cnt <= byte_cnt + 8'd1;
        end
      end
      if (pw_end) begin
        armed      <= 1'b0;
        byte_cnt   <= '0;
        txn_pushed <= 1'b0;
      end
    end
  end

  // FIFO pointers and fill level; reset empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // FIFO storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Next burst length: limited by fill level, burst size and distance to ring end
  always_comb begin
    cand     = CW'(level);
    ring_rem = CW'(ring - off);
    if (cand > CW'(BURST_LEN)) cand = CW'(BURST_LEN);
    if ((ring != '0) && (ring_rem < cand)) cand = ring_rem;
    len_calc = cand[7:0];
  end

  // DMA state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // DMA next-state and command handshake
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    accept   = 1'b0;
    done     = 1'b0;
    mi_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run && (len_calc != 8'd0) &&
            ((level >= BURST_LVL) || (flush && (level != '0)))) begin
          state_d = ST_CMD;
          launch  = 1'b1;
        end
      end
      ST_CMD: begin
        mi_valid = 1'b1;
        if (mi_ready) begin
          state_d = ST_WAIT;
          accept  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mi_wack && mi_wlast) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wishbone read mux over the four registers
  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      2'd0:    rd_mux = {16'(level), 12'd0, busy, ovf, flush, run};
      2'd1:    rd_mux = 32'(base + off);
      2'd2:    rd_mux = 32'(ring);
      default: rd_mux = wcount;
    endcase
  end

  // Control registers, burst bookkeeping and Wishbone handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      flush    <= 1'b0;
      ovf      <= 1'b0;
      base     <= '0;
      off      <= '0;
      ring     <= '0;
      wcount   <= '0;
      lenm1    <= '0;
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wb_ack  <= wb_cyc & ~wb_ack;
      wr_pend <= wb_cyc & ~wb_ack & wb_we;
      wr_addr <= wb_addr;
      wr_data <= wb_wdata;
      if (wb_cyc && !wb_ack) wb_rdata <= rd_mux;

      if (push_pend && full) ovf <= 1'b1;
      if (launch) lenm1 <= 7'(len_calc - 8'd1);
      if (accept) begin
        if ((ring != '0) && (off_sum == ring)) off <= '0;
        else                                   off <= off_sum;
      end
      if (done) wcount <= wcount + 32'(len);

      if (launch && (level <= BURST_LVL))          flush <= 1'b0;
      else if ((state_q == ST_IDLE) && (level == '0)) flush <= 1'b0;
      if (end_flush) flush <= 1'b1;

      if (wr_pend) begin
        case (wr_addr)
          2'd0: begin
            run <= wr_data[0];
            if (wr_data[1]) flush <= 1'b1;
            if (wr_data[2]) ovf   <= 1'b0;
          end
          2'd1: begin
            if (!busy) begin
              base <= wr_data[ADDR_WIDTH-1:0];
              off  <= '0;
            end
          end
          2'd2: begin
            if (!busy) ring <= wr_data[ADDR_WIDTH-1:0];
          end
          default: wcount <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_dev_memdma.sv
// tb_spi_dev_memdma: directed bench for the SPI-to-memory write DMA.
// A behavioural memory answers bursts and records addresses, lengths and data.
module tb_spi_dev_memdma;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pw_wdata;
  logic        pw_wcmd, pw_wstb, pw_end;
  logic [22:0] mi_addr;
  logic [6:0]  mi_len;
  logic        mi_rw, mi_valid, mi_ready;
  logic [15:0] mi_wdata;
  logic        mi_wack, mi_wlast;
  logic [15:0] mi_rdata;
  logic        mi_rstb, mi_rlast;
  logic [31:0] wb_wdata, wb_rdata;
  logic [1:0]  wb_addr;
  logic        wb_we, wb_cyc, wb_ack;

  int          compare_count = 0;
  int          fail_count = 0;
  logic        resp_en = 1'b1;
  logic        resp_busy = 1'b0;
  logic [15:0] mem_model [0:1023];
  int          max_addr = -1;
  int          burst_addr_q[$];
  int          burst_len_q[$];

  spi_dev_memdma dut (
    .clk(clk), .rst(rst),
    .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb), .pw_end(pw_end),
    .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
    .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wack(mi_wack), .mi_wlast(mi_wlast),
    .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast),
    .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_addr(wb_addr), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int q_addr(input int i);
    return (i < burst_addr_q.size()) ? burst_addr_q[i] : -1;
  endfunction

  function automatic int q_len(input int i);
    return (i < burst_len_q.size()) ? burst_len_q[i] : -1;
  endfunction

  function automatic int data_errs(input int base_idx, input int first, input int n);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (mem_model[(base_idx + i) % 1024] !== 16'(first + i)) e++;
    return e;
  endfunction

  // Behavioural memory: accepts each command after one cycle, then acks every word
  initial begin
    int ra, rn;
    mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mi_valid && resp_en) begin
        resp_busy = 1'b1;
        ra = int'(mi_addr);
        rn = int'(mi_len) + 1;
        mi_ready = 1'b1;
        @(posedge clk); #1;
        mi_ready = 1'b0;
        burst_addr_q.push_back(ra);
        burst_len_q.push_back(rn);
        for (int i = 0; i < rn; i++) begin
          mi_wack  = 1'b1;
          mi_wlast = (i == rn - 1);
          if (ra + i > max_addr) max_addr = ra + i;
          mem_model[(ra + i) % 1024] = mi_wdata;
          @(posedge clk); #1;
        end
        mi_wack = 1'b0; mi_wlast = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic c);
    pw_wdata = b; pw_wcmd = c; pw_wstb = 1'b1;
    @(posedge clk); #1;
    pw_wstb = 1'b0; pw_wcmd = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] first, input int n);
    logic [15:0] w;
    send_byte(8'he0, 1'b1);
    for (int i = 0; i < n; i++) begin
      w = first + 16'(i);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
    end
    pw_end = 1'b1;
    @(posedge clk); #1;
    pw_end = 1'b0;
  endtask

  task automatic wb_access(input logic [1:0] a, input logic we, input logic [31:0] d, output logic [31:0] q);
    logic got = 1'b0;
    q = '0;
    wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin
        got = 1'b1;
        q = wb_rdata;
      end
    end
    wb_cyc = 1'b0; wb_we = 1'b0;
    if (!got) checkOutput("wb_ack", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(a, 1'b1, d, dummy);
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] expected);
    logic [31:0] q;
    wb_access(a, 1'b0, 32'd0, q);
    checkOutput(tag, q, expected);
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    int cycles = 0;
    while (quiet < 30 && cycles < 4000) begin
      @(posedge clk); #1;
      cycles++;
      if (!mi_valid && !resp_busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 30) checkOutput("settle", 32'(quiet), 32'd30);
  endtask

  task automatic clear_log();
    burst_addr_q.delete();
    burst_len_q.delete();
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    pw_wdata = '0; pw_wcmd = 1'b0; pw_wstb = 1'b0; pw_end = 1'b0;
    wb_wdata = '0; wb_addr = '0; wb_we = 1'b0; wb_cyc = 1'b0;
    mi_rdata = '0; mi_rstb = 1'b0; mi_rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] reset state");
    checkOutput("rst_mi_valid", mi_valid, 32'd0);
    checkOutput("rst_mi_addr", mi_addr, 32'd0);
    checkOutput("rst_mi_len", mi_len, 32'd0);
    check_reg("rst_csr", 2'd0, 32'd0);
    check_reg("rst_base", 2'd1, 32'd0);
    check_reg("rst_ring", 2'd2, 32'd0);
    check_reg("rst_wcount", 2'd3, 32'd0);

    $display("[TB] full bursts");
    clear_log();
    wb_write(2'd1, 32'h100);
    wb_write(2'd0, 32'h1);
    applyStimulus(16'h0000, 128);
    wait_quiet();
    checkOutput("t1_nbursts", burst_addr_q.size(), 32'd2);
    checkOutput("t1_b0_addr", q_addr(0), 32'h100);
    checkOutput("t1_b0_len", q_len(0), 32'd64);
    checkOutput("t1_b1_addr", q_addr(1), 32'h140);
    checkOutput("t1_b1_len", q_len(1), 32'd64);
    checkOutput("t1_data", data_errs(32'h100, 0, 128), 32'd0);
    check_reg("t1_wcount", 2'd3, 32'd128);
    check_reg("t1_csr", 2'd0, 32'h1);

    $display("[TB] partial flush");
    clear_log();
    wb_write(2'd1, 32'h200);
    applyStimulus(16'h1000, 10);
    wait_quiet();
    checkOutput("t2_nbursts", burst_addr_q.size(), 32'd1);
    checkOutput("t2_b0_addr", q_addr(0), 32'h200);
    checkOutput("t2_b0_len", q_len(0), 32'd10);
    checkOutput("t2_data", data_errs(32'h200, 32'h1000, 10), 32'd0);
    check_reg("t2_csr", 2'd0, 32'h1);
    check_reg("t2_addr", 2'd1, 32'h20a);
    check_reg("t2_wcount", 2'd3, 32'd138);

    $display("[TB] ring wrap");
    clear_log();
    wb_write(2'd2, 32'd96);
    wb_write(2'd1, 32'h0);
    max_addr = -1;
    applyStimulus(16'h2000, 160);
    wait_quiet();
    checkOutput("t3_nbursts", burst_addr_q.size(), 32'd3);
    checkOutput("t3_b0_addr", q_addr(0), 32'd0);
    checkOutput("t3_b0_len", q_len(0), 32'd64);
    checkOutput("t3_b1_addr", q_addr(1), 32'd64);
    checkOutput("t3_b1_len", q_len(1), 32'd32);
    checkOutput("t3_b2_addr", q_addr(2), 32'd0);
    checkOutput("t3_b2_len", q_len(2), 32'd64);
    checkOutput("t3_max_addr", max_addr, 32'd95);
    checkOutput("t3_data", data_errs(0, 32'h2060, 64) + data_errs(64, 32'h2040, 32), 32'd0);
    check_reg("t3_wcount", 2'd3, 32'd298);

    $display("[TB] overflow");
    clear_log();
    wb_write(2'd2, 32'd0);
    wb_write(2'd1, 32'h300);
    wb_write(2'd0, 32'h0);
    applyStimulus(16'h0000, 300);
    wait_quiet();
    check_reg("t4_csr_full", 2'd0, 32'h0100_0006);
    wb_write(2'd0, 32'h1);
    wait_quiet();
    checkOutput("t4_nbursts", burst_addr_q.size(), 32'd4);
    checkOutput("t4_b3_addr", q_addr(3), 32'h3c0);
    checkOutput("t4_data", data_errs(32'h300, 0, 256), 32'd0);
    check_reg("t4_csr_drained", 2'd0, 32'h5);
    wb_write(2'd0, 32'h5);
    check_reg("t4_csr_ovf_clr", 2'd0, 32'h1);
    check_reg("t4_wcount", 2'd3, 32'd554);

    $display("[TB] run cleared mid-burst");
    clear_log();
    wb_write(2'd3, 32'h0);
    wb_write(2'd0, 32'h0);
    wb_write(2'd1, 32'h100);
    applyStimulus(16'h5000, 128);
    wb_write(2'd0, 32'h1);
    for (int i = 0; i < 50 && !resp_busy; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("t5_burst_started", resp_busy, 32'd1);
    wb_write(2'd0, 32'h0);
    wait_quiet();
    seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (mi_valid) seen++;
    end
    checkOutput("t5_no_relaunch", seen, 32'd0);
    checkOutput("t5_nbursts", burst_addr_q.size(), 32'd1);
    checkOutput("t5_b0_len", q_len(0), 32'd64);
    checkOutput("t5_data", data_errs(32'h100, 32'h5000, 64), 32'd0);
    check_reg("t5_wcount", 2'd3, 32'd64);
    check_reg("t5_csr", 2'd0, 32'h0040_0002);

    $display("[TB] async reset mid-command");
    resp_en = 1'b0;
    wb_write(2'd0, 32'h1);
    for (int i = 0; i < 20 && !mi_valid; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("t6_valid_before", mi_valid, 32'd1);
    #3 rst = 1'b1;
    #1 checkOutput("t6_valid_async", mi_valid, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_en = 1'b1;
    @(posedge clk); #1;
    check_reg("t6_csr", 2'd0, 32'd0);
    check_reg("t6_base", 2'd1, 32'd0);
    check_reg("t6_ring", 2'd2, 32'd0);
    check_reg("t6_wcount", 2'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule

// File: doc/spi_dev_memdma.md
# spi_dev_memdma

SPI-to-memory write DMA with streaming FIFO, partial-burst flush and ring-buffer addressing. It sits between the SPI protocol wrapper and the memory-interface arbiter. It assembles words from a repeated SPI write command, buffers them, and issues bursts of up to `BURST_LEN` words to memory. It is controlled and monitored over a 4-register Wishbone slave.

## Interface
Parameters:
- `CMD_BYTE`, 8'he0: SPI command byte that opens a data stream.
- `DATA_WIDTH`, 16: word width in bits. Must be a multiple of 8.
- `ADDR_WIDTH`, 23: memory word-address width.
- `BURST_LEN`, 64: maximum burst length in words. Power of 2, 1..128.
- `FIFO_DEPTH`, 256: FIFO depth in words. Power of 2, ≥ 2·`BURST_LEN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pw_wdata` in 8: SPI byte.
- `pw_wcmd` in 1: high with `pw_wstb` when the byte is the command byte.
- `pw_wstb` in 1: byte strobe.
- `pw_end` in 1: SPI transaction end (CS release), one-cycle pulse.
- `mi_addr` out `ADDR_WIDTH`: burst start word address.
- `mi_len` out 7: burst length − 1.
- `mi_rw` out 1: constant 0 (write).
- `mi_valid` out 1: command valid.
- `mi_ready` in 1: command accept.
- `mi_wdata` out `DATA_WIDTH`: write data, equal to the FIFO head (show-ahead).
- `mi_wack` in 1: memory consumed `mi_wdata`.
- `mi_wlast` in 1: qualifies the last `mi_wack` of a burst.
- `mi_rdata`, `mi_rstb`, `mi_rlast` in: unused.
- `wb_wdata` in 32, `wb_rdata` out 32, `wb_addr` in 2, `wb_we` in 1, `wb_cyc` in 1, `wb_ack` out 1: Wishbone slave.

## Operation
- **Stream decode.** A `pw_wstb`+`pw_wcmd` with data == `CMD_BYTE` arms the stream. Each following group of `DATA_WIDTH/8` bytes forms one word, first byte in the MSBs, and is pushed into the FIFO. This repeats until `pw_end`. A trailing partial word is discarded. Any other command byte disarms the stream.
- **FIFO full.** A push while the FIFO is full drops the word and sets the sticky flag `ovf`.
- **Level counter.** `level` is 0..`FIFO_DEPTH`. A push and a pop in the same cycle leave it unchanged.
- **Flush request.** `flush` is set by `pw_end` when at least one word was pushed in that transaction, or by a CSR write. It is cleared when a burst is launched with `level` ≤ `BURST_LEN`, or in IDLE when `level` == 0.
- **Registers.** `base` and `off` are `ADDR_WIDTH` bits; `ring` is `ADDR_WIDTH` bits, where 0 means linear addressing.
- **DMA state machine:**
  - IDLE → CMD when `run` and (`level` ≥ `BURST_LEN`, or (`flush` and `level` > 0)). On entry, latch `len` = min(`level`, `BURST_LEN`, `ring`−`off` if `ring`≠0).
  - CMD: `mi_valid`=1, `mi_addr`=`base`+`off` (mod 2^`ADDR_WIDTH`), `mi_len`=`len`−1. CMD → WAIT on `mi_ready`; in that same cycle `off` += `len`, and if `ring`≠0 and `off`+`len` == `ring`, `off` becomes 0.
  - WAIT: each `mi_wack` pops one word. WAIT → IDLE on `mi_wack & mi_wlast`; `wcount` += `len` in that cycle.
- **Bursts never cross the ring end.**
- **Clearing `run`** mid-burst: the current burst completes, and no new burst is launched.
- **Wishbone registers:**
  - addr 0 CSR. Write: bit0 `run`, bit1 = 1 sets `flush`, bit2 = 1 clears `ovf`. Read: bit0 `run`, bit1 `flush`, bit2 `ovf`, bit3 `busy` (state ≠ IDLE), [31:16] `level`.
  - addr 1 `base`. A write sets `base` and clears `off`. Read returns `base`+`off`.
  - addr 2 `ring`, read/write.
  - addr 3 `wcount` (32-bit, wraps). Read returns the count; any write clears it.
- **Writes while busy.** Writes to addr 1 and 2 while `busy` are ignored.

## Timing
- Reset values:
  - `mi_valid`, `wb_ack`, `run`, `flush`, `ovf` = 0.
  - `base`, `off`, `ring`, `wcount`, `level` = 0.
  - State IDLE.
  - `wb_rdata` = 0, `mi_len` = 0, `mi_addr` = 0.
- Reset mid-burst aborts immediately and empties the FIFO.
- Wishbone: `wb_ack` is asserted one cycle after `wb_cyc`, for one cycle. `wb_rdata` is registered and valid with `wb_ack`. Register writes take effect the cycle after `wb_ack`.
- Decode latency: a push happens 1 cycle after the last byte's `pw_wstb`. A word is visible at `mi_wdata` 1 cycle after the push.
- IDLE → CMD takes 1 cycle after the condition holds. `mi_valid` is held until `mi_ready`, and `mi_addr`/`mi_len` are stable while `mi_valid`=1.
- `mi_wdata` updates the cycle after each `mi_wack`. Memory issues at most one `mi_wack` per cycle.
- `pw_end` coinciding with the final push still sets `flush`.

## Test plan
- **Full bursts.** `run`=1, `base`=0x100, stream 128 words 0..127 → two CMDs: addr 0x100 len 63, then 0x140 len 63. Data is in order. `wcount`=128.
- **Partial flush.** Stream 10 words, then `pw_end` → one CMD len 9 at `base`. `flush` reads 0 afterwards.
- **Ring wrap.** `ring`=96, `base`=0, stream 160 words → bursts (0,64), (64,32), (0,64). Nothing is written at addresses ≥ 96.
- **Overflow.** `run`=0, stream 300 words → `level`=256, `ovf`=1. Set `run`=1 → 256 words delivered (words 0..255). Clear `ovf` → reads 0.
- **Run cleared mid-burst.** Clear `run` during WAIT → the burst completes with `mi_wlast`, and no further `mi_valid` appears with 64 words remaining.
- **Async reset mid-CMD.** Assert `rst` while `mi_valid`=1 → `mi_valid` drops without a clock edge, and all status reads return 0.
